// File: rtl/my_multicycle_datapath.sv
`timescale 1ns / 1ps
// Multi-cycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with handshaked memories,
// IR/A/B/Imm/ALUOut/MDR latches, register file, immediate generator, ALU and instret counter.
module my_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_in,
  input  logic             inst_valid,
  input  logic [31:0]      Data_in,
  input  logic             data_ack,
  input  logic [2:0]       ALU_Control,
  input  logic [1:0]       ImmSel,
  input  logic [1:0]       MemtoReg,
  input  logic             ALUSrc_B,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic             inst_req,
  output logic [31:0]      PC_out,
  output logic [31:0]      inst_field,
  output logic [31:0]      Addr_out,
  output logic [31:0]      Data_out,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      ALU_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, ir_q, a_q, b_q, imm_q, aluout_q, mdr_q;
  logic               zero_q;
  logic [CNT_W-1:0]   instret_q;
  logic [31:0]        rf_q [32];

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm_gen, alu_b, alu_res, wb_data, pc_next;
  logic        alu_zero, zero_sel, retire, rf_we;

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  // Immediate formats: 0 I, 1 S, 2 B, 3 J.
  always_comb begin
    imm_gen = 32'd0;
    case (ImmSel)
      2'd0: imm_gen = {{20{ir_q[31]}}, ir_q[31:20]};
      2'd1: imm_gen = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      2'd2: imm_gen = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      default: imm_gen = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    endcase
  end

  // ALU ops: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT.
  assign alu_b = ALUSrc_B ? imm_q : b_q;
  always_comb begin
    alu_res = 32'd0;
    case (ALU_Control)
      3'd0: alu_res = a_q & alu_b;
      3'd1: alu_res = a_q | alu_b;
      3'd2: alu_res = a_q + alu_b;
      3'd3: alu_res = a_q ^ alu_b;
      3'd4: alu_res = a_q << alu_b[4:0];
      3'd5: alu_res = a_q >> alu_b[4:0];
      3'd6: alu_res = a_q - alu_b;
      default: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  always_comb begin
    wb_data = aluout_q;
    case (MemtoReg)
      2'd0: wb_data = aluout_q;
      2'd1: wb_data = mdr_q;
      2'd2: wb_data = pc_q + 32'd4;
      default: wb_data = imm_q;
    endcase
  end

  // A branch retiring straight from EXEC has not latched its zero flag yet.
  assign zero_sel = (state_q == StExec) ? alu_zero : zero_q;
  assign pc_next  = (Jump || (Branch && zero_sel)) ? (pc_q + imm_q) : (pc_q + 32'd4);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (inst_valid) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (MemRead || MemWrite) begin
          state_d = StMem;
        end else if (RegWrite) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StMem: begin
        if (data_ack) begin
          if (MemRead) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0013;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      imm_q     <= 32'd0;
      aluout_q  <= 32'd0;
      mdr_q     <= 32'd0;
      zero_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && inst_valid) ir_q <= inst_in;
      if (state_q == StDecode) begin
        a_q   <= rs1_data;
        b_q   <= rs2_data;
        imm_q <= imm_gen;
      end
      if (state_q == StExec) begin
        aluout_q <= alu_res;
        zero_q   <= alu_zero;
      end
      if (state_q == StMem && data_ack && MemRead) mdr_q <= Data_in;
      if (retire) begin
        pc_q      <= pc_next;
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign rf_we = RegWrite && (state_q == StWb) && !rst;
  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0) rf_q[rd] <= wb_data;
  end

  assign inst_req   = (state_q == StFetch);
  assign PC_out     = pc_q;
  assign inst_field = ir_q;
  assign Addr_out   = aluout_q;
  assign Data_out   = b_q;
  assign mem_rd     = (state_q == StMem) && MemRead;
  assign mem_wr     = (state_q == StMem) && MemWrite && !MemRead;
  assign ALU_out    = aluout_q;
  assign state_out  = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_my_multicycle_datapath.sv
`timescale 1ns / 1ps
// Bench for my_multicycle_datapath: an instruction-level model predicts per-cycle outputs,
// a single negedge process compares them, plus literal PC/data spot values.
module tb_my_multicycle_datapath;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, inst_valid, data_ack, ALUSrc_B, Jump, Branch, RegWrite, MemRead, MemWrite;
  logic [31:0] inst_in, Data_in;
  logic [2:0]  ALU_Control;
  logic [1:0]  ImmSel, MemtoReg;
  logic        inst_req, mem_rd, mem_wr;
  logic [31:0] PC_out, inst_field, Addr_out, Data_out, ALU_out, instret;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  my_multicycle_datapath #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid), .Data_in(Data_in),
    .data_ack(data_ack), .ALU_Control(ALU_Control), .ImmSel(ImmSel), .MemtoReg(MemtoReg),
    .ALUSrc_B(ALUSrc_B), .Jump(Jump), .Branch(Branch), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .inst_req(inst_req), .PC_out(PC_out),
    .inst_field(inst_field), .Addr_out(Addr_out), .Data_out(Data_out), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .ALU_out(ALU_out), .state_out(state_out), .instret(instret)
  );

  typedef struct {
    logic [2:0]  st;
    logic [31:0] pc, ir, icnt, addr, dout, alu;
    logic        req, rd, wr, chk_ir, chk_mem, chk_alu;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;

  exp_t q[$];
  lit_t lq[$];
  int   checks = 0;
  int   errors = 0;

  // Instruction-level model state.
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_cnt;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    lit_t l;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp("state", {29'd0, state_out}, {29'd0, e.st});
      cmp("pc", PC_out, e.pc);
      cmp("instret", instret, e.icnt);
      cmp("inst_req", {31'd0, inst_req}, {31'd0, e.req});
      cmp("mem_rd", {31'd0, mem_rd}, {31'd0, e.rd});
      cmp("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
      if (e.chk_ir) cmp("inst_field", inst_field, e.ir);
      if (e.chk_mem) begin
        cmp("addr", Addr_out, e.addr);
        cmp("dout", Data_out, e.dout);
      end
      if (e.chk_alu) cmp("alu_out", ALU_out, e.alu);
    end
    while (lq.size() != 0) begin
      l = lq.pop_front();
      cmp(l.nm, l.act, l.exp);
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_t l;
    l.nm = nm; l.act = act; l.exp = exp;
    lq.push_back(l);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input logic [31:0] ir, input logic ci,
                      input logic cm, input logic ca, input logic [31:0] alu,
                      input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] dout);
    exp_t e;
    e.st = st; e.pc = m_pc; e.icnt = m_cnt; e.ir = ir; e.req = (st == 3'd0);
    e.rd = rd; e.wr = wr; e.chk_ir = ci; e.chk_mem = cm; e.chk_alu = ca;
    e.alu = alu; e.addr = addr; e.dout = dout;
    q.push_back(e);
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd3: return x ^ y;
      3'd4: return x << y[4:0];
      3'd5: return x >> y[4:0];
      3'd6: return x - y;
      default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] imm_ref(input logic [1:0] sel, input logic [31:0] i);
    case (sel)
      2'd0: return {{20{i[31]}}, i[31:20]};
      2'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // Runs one instruction; iw/aw are wait cycles before inst_valid/data_ack.
  // rst_mem asserts reset on the last MEM cycle instead of acknowledging.
  task automatic run(input logic [31:0] inst, input logic [2:0] op, input logic [1:0] isel,
                     input logic [1:0] m2r, input logic srcb, input logic jmp, input logic br,
                     input logic rw, input logic mr, input logic mw, input int iw, input int aw,
                     input logic [31:0] din, input bit rst_mem);
    logic [31:0] a, b, imm, res, wd;
    logic        ismem, wb;
    ALU_Control = op; ImmSel = isel; MemtoReg = m2r; ALUSrc_B = srcb; Jump = jmp;
    Branch = br; RegWrite = rw; MemRead = mr; MemWrite = mw;
    a     = (inst[19:15] == 5'd0) ? 32'd0 : m_rf[inst[19:15]];
    b     = (inst[24:20] == 5'd0) ? 32'd0 : m_rf[inst[24:20]];
    imm   = imm_ref(isel, inst);
    res   = alu_ref(op, a, srcb ? imm : b);
    ismem = mr | mw;
    wb    = ismem ? mr : rw;
    for (int i = 0; i <= iw; i++) begin
      inst_valid = (i == iw);
      inst_in    = (i == iw) ? inst : ~inst;
      push(3'd0, inst, 1'b0, 1'b0, 1'b0, res, 1'b0, 1'b0, res, b);
      step();
    end
    inst_valid = 1'b0;
    inst_in    = 32'd0;
    push(3'd1, inst, 1'b1, 1'b0, 1'b0, res, 1'b0, 1'b0, res, b);
    step();
    data_ack = 1'b1;  // stray ack outside MEM must be ignored
    Data_in  = 32'h1234_5678;
    push(3'd2, inst, 1'b1, 1'b0, 1'b0, res, 1'b0, 1'b0, res, b);
    step();
    data_ack = 1'b0;
    if (ismem) begin
      for (int j = 0; j <= aw; j++) begin
        if (rst_mem && j == aw) begin
          data_ack = 1'b0;
          rst      = 1'b1;
          push(3'd3, inst, 1'b1, 1'b1, 1'b1, res, mr, mw & ~mr, res, b);
          step();
          rst   = 1'b0;
          m_pc  = RST_PC;
          m_cnt = 32'd0;
          return;
        end
        data_ack = (j == aw);
        Data_in  = (j == aw) ? din : ~din;
        push(3'd3, inst, 1'b1, 1'b1, 1'b1, res, mr, mw & ~mr, res, b);
        step();
      end
      data_ack = 1'b0;
    end
    if (wb) begin
      push(3'd4, inst, 1'b1, 1'b0, 1'b1, res, 1'b0, 1'b0, res, b);
      step();
      case (m2r)
        2'd0: wd = res;
        2'd1: wd = din;
        2'd2: wd = m_pc + 32'd4;
        default: wd = imm;
      endcase
      if (inst[11:7] != 5'd0) m_rf[inst[11:7]] = wd;
    end
    m_pc  = (jmp || (br && res == 32'd0)) ? m_pc + imm : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
    inst_in = 32'd0; inst_valid = 1'b0; Data_in = 32'd0; data_ack = 1'b0;
    ALU_Control = 3'd0; ImmSel = 2'd0; MemtoReg = 2'd0; ALUSrc_B = 1'b0; Jump = 1'b0;
    Branch = 1'b0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst   = 1'b0;
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    lit("rst_state", {29'd0, state_out}, 32'd0);
    lit("rst_pc", PC_out, 32'h0);
    lit("rst_ir", inst_field, 32'h0000_0013);
    lit("rst_instret", instret, 32'd0);
    lit("rst_alu", ALU_out, 32'd0);
    lit("rst_req", {31'd0, inst_req}, 32'd1);
    lit("rst_memrw", {30'd0, mem_rd, mem_wr}, 32'd0);

    // addi x1,x0,5
    run(32'h0050_0093, 3'd2, 2'd0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0, 32'd0, 0);
    lit("addi_pc", PC_out, 32'h4);
    lit("addi_instret", instret, 32'd1);
    // sw x1,8(x0), ack after 3 waits
    run(32'h0010_2423, 3'd2, 2'd1, 2'd0, 1, 0, 0, 0, 0, 1, 0, 3, 32'd0, 0);
    // lw x2,8(x0), ack after 1 wait
    run(32'h0080_2103, 3'd2, 2'd0, 2'd1, 1, 0, 0, 1, 1, 0, 0, 1, 32'hDEAD_BEEF, 0);
    // add x3,x1,x2 with two fetch wait cycles
    run(32'h0020_81B3, 3'd2, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 2, 0, 32'd0, 0);
    lit("add_alu", ALU_out, 32'hDEAD_BEF4);
    lit("add_pc", PC_out, 32'h10);
    // beq x0,x0,+16 taken, then beq x1,x0,+16 not taken
    run(32'h0000_0863, 3'd6, 2'd2, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd0, 0);
    lit("beq_taken_pc", PC_out, 32'h20);
    run(32'h0000_8863, 3'd6, 2'd2, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd0, 0);
    lit("beq_nt_pc", PC_out, 32'h24);
    // jal x1,+0x1C then jal x1,+0x100
    run(32'h01C0_00EF, 3'd2, 2'd3, 2'd2, 1, 1, 0, 1, 0, 0, 0, 0, 32'd0, 0);
    lit("jal1_pc", PC_out, 32'h40);
    run(32'h1000_00EF, 3'd2, 2'd3, 2'd2, 1, 1, 0, 1, 0, 0, 0, 0, 32'd0, 0);
    lit("jal2_pc", PC_out, 32'h140);
    // sw x1,4(x0) exposes the link value
    run(32'h0010_2223, 3'd2, 2'd1, 2'd0, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 0);
    lit("link_data", Data_out, 32'h44);
    // x4 <- Imm(-3) via MemtoReg=3, then sw x4,12(x0)
    run(32'hFFD0_0213, 3'd3, 2'd0, 2'd3, 1, 0, 0, 1, 0, 0, 0, 0, 32'd0, 0);
    run(32'h0040_2623, 3'd2, 2'd1, 2'd0, 1, 0, 0, 0, 0, 1, 0, 1, 32'd0, 0);
    lit("imm_wb_data", Data_out, 32'hFFFF_FFFD);
    // and x5,x3,x1
    run(32'h0011_F2B3, 3'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd0, 0);
    lit("and_alu", ALU_out, 32'h44);
    // lw x1,8(x0) with MemWrite also set, reset during MEM without ack
    run(32'h0080_2083, 3'd2, 2'd0, 2'd1, 1, 0, 0, 1, 1, 1, 0, 2, 32'hCAFE_F00D, 1);
    lit("abort_state", {29'd0, state_out}, 32'd0);
    lit("abort_pc", PC_out, RST_PC);
    lit("abort_instret", instret, 32'd0);
    lit("abort_memrd", {31'd0, mem_rd}, 32'd0);
    // x1 must still hold the link value
    run(32'h0010_2223, 3'd2, 2'd1, 2'd0, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 0);
    lit("abort_x1", Data_out, 32'h44);
    step();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
